bitstream_loader: RTL
=====================

// Module: bitstream_loader
// PURPOSE
//  Upstream driver of the fabric configuration scan chain (LUT bits, then prog_mux select, per BEL).
//  Accepts a byte stream from the host interface and serialises it MSB-first onto prog_in.
//  Generates prog_clk/prog_en for the chain and captures the bits leaving the chain tail as readback.
//  Sits between the host byte link (UART/SPI deframer) and the first BEL in the chain.
// PARAMETERS
//  CHAIN_LEN    1024  total config bits in chain; last byte's unused low bits are discarded
//  HALF_PERIOD  1     clk cycles per prog_clk phase (low and high), >=1
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous reset, active-high
//  start        in   1        1-cycle pulse; begins a load when idle, ignored otherwise
//  abort        in   1        terminates load, returns to IDLE (priority over start/stream)
//  s_data       in   8        config byte from host
//  s_valid      in   1        s_data valid
//  s_ready      out  1        byte accepted on s_valid & s_ready
//  prog_clk     out  1        chain shift clock (registered, glitch-free)
//  prog_en      out  1        chain shift enable
//  prog_in      out  1        serial data into chain head
//  chain_tail   in   1        prog_out of last chain element
//  rb_data      out  8        readback byte, first-exited bit in MSB
//  rb_valid     out  1        1-cycle pulse, rb_data valid
//  busy         out  1        high in any state except IDLE
//  done         out  1        1-cycle pulse when CHAIN_LEN bits shifted
//  bit_count    out  $clog2(CHAIN_LEN+1)  bits shifted in current load
// BEHAVIOUR
//  Reset: IDLE; prog_clk=0, prog_en=0, prog_in=0, s_ready=0, rb_valid=0, rb_data=0, busy=0,
//   done=0, bit_count=0. Reset mid-load discards partial state; chain contents undefined.
//  States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, DONE.
//  IDLE: start -> FETCH; bit_count cleared; prog_en asserted from next cycle.
//  FETCH: s_ready=1 (combinational from state). On s_valid: latch byte into shift reg,
//   bit_idx=7 -> SHIFT_LO. No byte -> stay; prog_clk held 0, prog_en held 1.
//  SHIFT_LO: prog_clk=0, prog_in=sreg[7] for HALF_PERIOD cycles; on the last cycle
//   chain_tail is sampled into readback reg -> SHIFT_HI.
//  SHIFT_HI: prog_clk=1 for HALF_PERIOD cycles (chain shifts on rising edge);
//   on exit bit_count+=1, sreg<<=1. Then: bit_count==CHAIN_LEN -> DONE;
//   else bit_idx==0 -> FETCH; else bit_idx-=1 -> SHIFT_LO.
//  One bit per 2*HALF_PERIOD clk; byte-to-byte gap >=1 FETCH cycle.
//  Readback: every 8 sampled bits -> rb_data, rb_valid pulse same cycle as 8th SHIFT_HI exit.
//   Final partial group (CHAIN_LEN%8) emitted left-aligned, zero-padded, at DONE entry.
//  DONE: prog_en=0, prog_clk=0, done=1 for exactly one cycle -> IDLE. Unused byte bits dropped.
//  abort in any state: next cycle IDLE, prog_en=0, prog_clk=0, no done, no rb_valid.
//  start while busy ignored. s_valid outside FETCH ignored (s_ready=0).
//  prog_in holds last value outside SHIFT_LO; prog_clk never toggles while prog_en=0.
// TESTING
//  CHAIN_LEN=16, HALF_PERIOD=1, bytes 0xA5,0x3C back-to-back -> prog_in seq 1010010100111100,
//   16 prog_clk rising edges, done pulse once, bit_count=16, prog_en low after.
//  Loop chain_tail through 16-bit shift-reg model preloaded 0xBEEF -> rb 0xBE then 0xEF;
//   second load returns 0xA5,0x3C.
//  CHAIN_LEN=12, bytes 0xFF,0x0F -> 12 edges, prog_in 1111_1111_0000, last 4 bits dropped,
//   rb second byte left-aligned with low nibble zero.
//  s_valid low 5 cycles between bytes -> prog_clk held 0, prog_en 1, no extra edges.
//  abort after 5 bits -> IDLE next cycle, prog_en=0, no done; new start loads cleanly from bit 0.
//  HALF_PERIOD=3 -> prog_clk 3 low/3 high; rst mid-SHIFT_HI -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/bitstream_loader_if.sv
// Signal bundle between the host byte link, the bitstream loader and the
// configuration scan chain.
interface bitstream_loader_if #(
  parameter int CHAIN_LEN = 1024
);
  localparam int CW = $clog2(CHAIN_LEN + 1);

  // Byte handshake: s_data moves on a rising clk where s_valid & s_ready are
  // both high. s_valid may rise at any time and is ignored while s_ready is
  // low; s_ready is high only while the loader waits for its next byte.
  logic          start;
  logic          abort;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          prog_clk;
  logic          prog_en;
  logic          prog_in;
  logic          chain_tail;
  logic [7:0]    rb_data;
  logic          rb_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_count;

  modport master (
    output start, abort, s_data, s_valid, chain_tail,
    input  s_ready, prog_clk, prog_en, prog_in, rb_data, rb_valid, busy, done, bit_count
  );

  modport slave (
    input  start, abort, s_data, s_valid, chain_tail,
    output s_ready, prog_clk, prog_en, prog_in, rb_data, rb_valid, busy, done, bit_count
  );
endinterface

// File: rtl/bitstream_loader.sv
// Serialises host config bytes MSB-first into the fabric scan chain, drives
// prog_clk/prog_en and packs the bits leaving the chain tail into readback bytes.
module bitstream_loader #(
  parameter int CHAIN_LEN   = 1024,
  parameter int HALF_PERIOD = 1
) (
  input  logic              clk,
  input  logic              rst,
  bitstream_loader_if.slave bus,
  output logic [2:0]        o_dbg_state
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [HW-1:0] HP_LAST  = HW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t        r_state;
  logic [6:0]    r_sreg;       // bits still to send after the one on prog_in
  logic [2:0]    r_bit_idx;
  logic [CW-1:0] r_bit_count;
  logic [HW-1:0] r_hp_cnt;
  logic [7:0]    r_rb_sreg;
  logic [2:0]    r_rb_cnt;
  logic          r_prog_clk;
  logic          r_prog_en;
  logic          r_prog_in;
  logic [7:0]    r_rb_data;
  logic          r_rb_valid;
  logic          r_done;

  logic          w_phase_end;
  logic          w_last_bit;
  logic          w_group_full;

  assign w_phase_end  = (r_hp_cnt == HP_LAST);
  assign w_last_bit   = (r_bit_count == LAST_BIT);
  assign w_group_full = (r_rb_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_bit_idx   <= '0;
      r_bit_count <= '0;
      r_hp_cnt    <= '0;
      r_rb_sreg   <= '0;
      r_rb_cnt    <= '0;
      r_prog_clk  <= 1'b0;
      r_prog_en   <= 1'b0;
      r_prog_in   <= 1'b0;
      r_rb_data   <= '0;
      r_rb_valid  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      r_done     <= 1'b0;
      if (bus.abort) begin
        // prog_clk drops together with prog_en so the chain never sees a runt pulse
        r_state    <= S_IDLE;
        r_prog_en  <= 1'b0;
        r_prog_clk <= 1'b0;
        r_hp_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_state     <= S_FETCH;
              r_bit_count <= '0;
              r_rb_cnt    <= '0;
              r_prog_en   <= 1'b1;
            end
          end
          S_FETCH: begin
            if (bus.s_valid) begin
              r_prog_in <= bus.s_data[7];
              r_sreg    <= bus.s_data[6:0];
              r_bit_idx <= 3'd7;
              r_hp_cnt  <= '0;
              r_state   <= S_SHIFT_LO;
            end
          end
          S_SHIFT_LO: begin
            if (w_phase_end) begin
              r_rb_sreg  <= {r_rb_sreg[6:0], bus.chain_tail};
              r_hp_cnt   <= '0;
              r_prog_clk <= 1'b1;
              r_state    <= S_SHIFT_HI;
            end else begin
              r_hp_cnt <= r_hp_cnt + 1'b1;
            end
          end
          S_SHIFT_HI: begin
            if (w_phase_end) begin
              r_hp_cnt    <= '0;
              r_prog_clk  <= 1'b0;
              r_bit_count <= r_bit_count + 1'b1;
              r_rb_cnt    <= r_rb_cnt + 1'b1;
              // a short final group is left-aligned so its first bit stays in the MSB
              if (w_group_full) begin
                r_rb_data  <= r_rb_sreg;
                r_rb_valid <= 1'b1;
              end else if (w_last_bit) begin
                r_rb_data  <= r_rb_sreg << (3'd7 - r_rb_cnt);
                r_rb_valid <= 1'b1;
              end
              if (w_last_bit) begin
                r_state   <= S_DONE;
                r_prog_en <= 1'b0;
                r_done    <= 1'b1;
              end else if (r_bit_idx == 3'd0) begin
                r_state <= S_FETCH;
              end else begin
                r_bit_idx <= r_bit_idx - 1'b1;
                r_prog_in <= r_sreg[6];
                r_sreg    <= {r_sreg[5:0], 1'b0};
                r_state   <= S_SHIFT_LO;
              end
            end else begin
              r_hp_cnt <= r_hp_cnt + 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.s_ready   = (r_state == S_FETCH);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.prog_clk  = r_prog_clk;
  assign bus.prog_en   = r_prog_en;
  assign bus.prog_in   = r_prog_in;
  assign bus.rb_data   = r_rb_data;
  assign bus.rb_valid  = r_rb_valid;
  assign bus.done      = r_done;
  assign bus.bit_count = r_bit_count;
  assign o_dbg_state   = r_state;
endmodule
